// File: rtl/bsg_credit_token_returner.sv
// bsg_credit_token_returner: decimates credit-release pulses into token pulses
// (plus a toggle form) with optional post-reset margin grant and minimum token spacing. Rev 1.0
`default_nettype none

module bsg_credit_token_returner #(
  parameter int lg_credit_to_token_decimation_p = 0,
  parameter int max_credits_p                   = 16,
  parameter int margin_tokens_p                 = 0,
  parameter int min_gap_p                       = 0
) (
  input  logic                               w_clk_i,
  input  logic                               w_reset_i,
  input  logic                               w_credit_v_i,
  input  logic                               w_hold_i,
  output logic                               w_token_o,
  output logic                               w_token_toggle_o,
  output logic [$clog2(max_credits_p+1)-1:0] w_pending_o,
  output logic                               w_overflow_o,
  output logic                               w_granting_o
);

  localparam int PW = $clog2(max_credits_p + 1);
  localparam int GW = (min_gap_p > 0) ? $clog2(min_gap_p + 1) : 1;
  localparam int CW = (margin_tokens_p > 0) ? $clog2(margin_tokens_p + 1) : 1;

  localparam logic [PW-1:0] D_L      = PW'(1 << lg_credit_to_token_decimation_p);
  localparam logic [PW-1:0] MAX_L    = PW'(max_credits_p);
  localparam logic [GW-1:0] GAP_L    = GW'(min_gap_p);
  localparam logic [CW-1:0] MARGIN_L = CW'(margin_tokens_p);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  localparam state_e RESET_STATE = (margin_tokens_p > 0) ? S_GRANT : S_RUN;

  state_e        state_r;
  logic [CW-1:0] grant_cnt_r;
  logic [GW-1:0] gap_r;
  logic [PW-1:0] pending_r;
  logic          token_r;
  logic          toggle_r;
  logic          overflow_r;

  logic          can_emit;
  logic          emit;
  logic          run_emit;
  logic          accept;
  logic [PW-1:0] pending_n;

  // Intermediate pending_r+1 may wrap when full, but the RUN-emit subtraction
  // brings the modular result back in range.
  always_comb begin
    can_emit  = (state_r == S_GRANT) ? (grant_cnt_r != '0) : (pending_r >= D_L);
    emit      = (gap_r == '0) && !w_hold_i && can_emit;
    run_emit  = emit && (state_r == S_RUN);
    accept    = w_credit_v_i && ((pending_r < MAX_L) || run_emit);
    pending_n = pending_r + PW'(accept) - (run_emit ? D_L : '0);
  end

  always_ff @(posedge w_clk_i or posedge w_reset_i) begin
    if (w_reset_i) begin
      state_r     <= RESET_STATE;
      grant_cnt_r <= MARGIN_L;
      gap_r       <= '0;
      pending_r   <= '0;
      token_r     <= 1'b0;
      toggle_r    <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      pending_r <= pending_n;
      token_r   <= emit;
      if (emit) toggle_r <= ~toggle_r;
      if (w_credit_v_i && !accept) overflow_r <= 1'b1;

      if (emit) gap_r <= GAP_L;
      else if (gap_r != '0) gap_r <= gap_r - GW'(1);

      if (emit && (state_r == S_GRANT)) begin
        grant_cnt_r <= grant_cnt_r - CW'(1);
        if (grant_cnt_r == CW'(1)) state_r <= S_RUN;
      end
    end
  end

  assign w_token_o        = token_r;
  assign w_token_toggle_o = toggle_r;
  assign w_pending_o      = pending_r;
  assign w_overflow_o     = overflow_r;
  assign w_granting_o     = (state_r == S_GRANT);

endmodule

`default_nettype wire

// File: doc/bsg_credit_token_returner.md
# bsg_credit_token_returner

Write-domain credit-return stage that sits directly upstream of the async credit counter. It collects single-credit release pulses from the receiving buffer, decimates them into tokens worth 2^lg_credit_to_token_decimation_p credits each, and emits one-cycle token pulses that drive the counter's w_inc_token_i. It also emits a toggle version that can be driven over a pin. After reset it can optionally issue a fixed number of margin tokens, and it enforces a minimum spacing between tokens to bound the toggle rate.

## Interface
- lg_credit_to_token_decimation_p, 0: log2 of the number of credits per token; D = 2^lg_credit_to_token_decimation_p.
- max_credits_p, 16: capacity of the pending-credit accumulator; must be >= D.
- margin_tokens_p, 0: tokens emitted unconditionally after reset (extra margin grant).
- min_gap_p, 0: minimum idle cycles between two token pulses.
- w_clk_i  in  1  clock; all logic is posedge.
- w_reset_i  in  1  reset, asynchronous, active-high; clock w_clk_i.
- w_credit_v_i  in  1  one credit released this cycle.
- w_hold_i  in  1  suppresses token emission this cycle (link not ready); credits still accumulate.
- w_token_o  out  1  one-cycle token pulse, registered; connects to the counter's w_inc_token_i.
- w_token_toggle_o  out  1  flips once per emitted token, registered.
- w_pending_o  out  $clog2(max_credits_p+1)  credits accumulated but not yet tokenised.
- w_overflow_o  out  1  sticky error: a credit arrived while the accumulator was full.
- w_granting_o  out  1  high while in the GRANT state.

## Operation
- Two states:
  - GRANT: entered on reset when margin_tokens_p > 0.
  - RUN: the reset state when margin_tokens_p == 0.
- Emission is allowed this cycle (emit) when all of the following hold: gap_r == 0, !w_hold_i, and the state condition.
  - GRANT: grant_cnt_r > 0.
  - RUN: pending_r >= D.
- GRANT:
  - Each emit decrements grant_cnt_r (loaded with margin_tokens_p at reset).
  - The emit that brings grant_cnt_r to 0 moves the state to RUN at the same edge.
  - Grant emits do not consume pending credits; credits keep accumulating during GRANT.
- RUN: each emit subtracts D from pending_r.
- Accumulator update per edge: pending_n = pending_r + accepted credit − (RUN emit ? D : 0).
  - The credit is accepted when w_credit_v_i is high and (pending_r < max_credits_p, or a RUN emit occurs this cycle).
  - A simultaneous credit and RUN emit is legal; pending_r never exceeds max_credits_p.
- Overflow: w_credit_v_i with pending_r == max_credits_p and no RUN emit drops the credit and sets w_overflow_o. It stays set until reset.
- Gap counter:
  - On an emit, gap_r loads min_gap_p.
  - Otherwise it decrements while nonzero.
  - With min_gap_p == 0, back-to-back tokens are possible every cycle.
- Token outputs:
  - On an emit edge, w_token_o is set for one cycle and w_token_toggle_o inverts.
  - Otherwise w_token_o is 0.
- Partial tokens (pending_r < D) are never emitted; they remain pending indefinitely.

## Timing
- Reset values (asynchronous, applied immediately on w_reset_i):
  - w_token_o=0, w_token_toggle_o=0, w_pending_o=0, w_overflow_o=0, gap_r=0, grant_cnt_r=margin_tokens_p.
  - w_granting_o = (margin_tokens_p > 0).
- Reset asserted mid-operation discards pending credits and any in-progress grant. Downstream must reset the counter alongside this block.
- Latency, with D=1, no hold, gap 0:
  - Credit sampled at edge k → pending_r=1 after edge k.
  - Emit is decided in cycle k→k+1 → w_token_o is high after edge k+1, and pending_r drops at that same edge.
- First grant token: w_token_o high after the first clock edge following reset deassertion.
- w_hold_i is sampled combinationally in the decision cycle; a hold at edge k blocks an emit at edge k only.
- Sustained throughput: one token per (min_gap_p+1) cycles.

## Test plan
- D=4, min_gap_p=0, margin 0; 10 credit pulses on consecutive cycles → 2 token pulses, 1 cycle after pending reaches 4 and 8; then w_pending_o=2 and toggle=0.
- margin_tokens_p=3, min_gap_p=2; release reset with no credits → tokens after edges 1, 4, 7; w_granting_o falls with the third token; no further tokens.
- D=1, min_gap_p=0; w_hold_i high for 5 cycles while 5 credits arrive → w_pending_o=5, no tokens; hold drops → 5 consecutive token pulses, pending returns to 0.
- max_credits_p=4, D=4, hold high; 6 credits → pending saturates at 4 and w_overflow_o=1 on the 5th credit. After hold releases, one token is emitted and overflow remains 1 until reset.
- D=2; a credit arrives on the same cycle as a RUN emit with pending_r=max_credits_p → credit accepted, pending = max−2+1, no overflow.
- Assert w_reset_i asynchronously between edges with pending=3 and gap_r nonzero → all outputs return to reset values immediately, without a clock edge.
